inst_loader: RTL and testbench
==============================

INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 Parameter ADDR_WIDTH, default 15, SHALL set the instruction-RAM word-address width.
REQ-002 Parameter BASE_ADDR, default 0, SHALL set the first word address written.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rstn  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle pulse SHALL arm a load.
REQ-006 rx_data  input  8  byte from the UART receiver.
REQ-007 rx_valid  input  1  SHALL mark rx_data valid.
REQ-008 rx_ready  output  1  SHALL signal byte acceptance; a byte transfers when rx_valid && rx_ready.
REQ-009 ram_addr  output  ADDR_WIDTH  SHALL drive the instruction-RAM write port address.
REQ-010 ram_enable  output  1  SHALL drive the RAM port enable.
REQ-011 ram_write_enable  output  1  SHALL drive the RAM port write enable.
REQ-012 ram_write_data  output  32  SHALL drive the assembled word.
REQ-013 busy  output  1  SHALL be high from start acceptance until the DONE or ERROR state is entered.
REQ-014 done  output  1  SHALL be a one-cycle pulse on successful completion.
REQ-015 error  output  1  SHALL be a level, held until the next accepted start.

Function
REQ-016 States SHALL be IDLE, LEN, DATA, WRITE, DONE, ERROR.
REQ-017 IDLE: rx_ready=0; start SHALL move to LEN, clear the byte and word counters, clear error, and load ram_addr=BASE_ADDR.
REQ-018 LEN: rx_ready=1; 4 bytes SHALL form word count N, little-endian (first byte = bits 7:0).
REQ-019 After the 4th LEN byte: N=0 SHALL go to DONE; N > 2^ADDR_WIDTH - BASE_ADDR SHALL go to ERROR; otherwise SHALL go to DATA.
REQ-020 DATA: rx_ready=1; 4 bytes SHALL be assembled little-endian; the cycle after the 4th byte is accepted the block SHALL be in WRITE.
REQ-021 WRITE: exactly one cycle; ram_enable=1, ram_write_enable=1, ram_write_data=assembled word, rx_ready=0.
REQ-022 Leaving WRITE: ram_addr SHALL increment by 1 and the word counter SHALL increment; the next state SHALL be DONE if the count equals N, else DATA.
REQ-023 ram_enable and ram_write_enable SHALL be 0 in every state except WRITE.
REQ-024 DONE: done SHALL be 1 for one cycle, then the block SHALL return to IDLE.
REQ-025 ERROR: error SHALL be 1 and rx_ready SHALL be 0; the block SHALL return to IDLE on the next cycle while error stays high.
REQ-026 start SHALL be ignored in any state other than IDLE.
REQ-027 Gaps in rx_valid SHALL stall assembly with no byte loss or duplication.
REQ-028 The sustained rate SHALL be one byte per cycle, with one stall cycle per word for WRITE.
REQ-029 Address arithmetic SHALL be ADDR_WIDTH-bit; REQ-019 guarantees that no wrap occurs.
REQ-030 Counters SHALL be 33 bits wide, or the N comparison SHALL be done at full 32-bit width, so that N=0xFFFFFFFF does not alias.

Reset
REQ-031 rstn low SHALL immediately force IDLE.
REQ-032 rstn low SHALL immediately force the following outputs to 0: rx_ready, ram_enable, ram_write_enable, busy, done, error, ram_addr, ram_write_data.
REQ-033 Reset asserted mid-load SHALL abandon the load without issuing any further RAM write.
REQ-034 Words already written before a mid-load reset SHALL NOT be rolled back.

Structure
REQ-035 A shared package SHALL hold the state enum type.
REQ-036 The same package SHALL hold the length-header byte count constant (4) and the word byte count constant (4).
REQ-037 A sub-module byte_assembler SHALL perform the 8-to-32 little-endian packing with a 2-bit byte index and a word-complete flag.
REQ-038 The same byte_assembler SHALL be reused for both the LEN and DATA phases.

Verification
REQ-039 start; bytes 02 00 00 00, EF BE AD DE, 78 56 34 12 -> writes addr0=0xDEADBEEF and addr1=0x12345678; one done pulse; busy low afterwards.
REQ-040 start; bytes 00 00 00 00 -> no RAM write; done pulses 5 cycles after start (IDLE->LEN takes 1 cycle, 4 byte cycles).
REQ-041 ADDR_WIDTH=4, BASE_ADDR=0; length 0x11 -> error=1, no write, rx_ready=0; a new start clears error.
REQ-042 rx_valid toggling 1,0,0,1 for a 1-word load -> exactly one write, with the correct word.
REQ-043 rstn pulsed low after 2 of 4 data bytes -> ram_write_enable never rises; outputs are 0 during reset; a following fresh load writes from BASE_ADDR.
REQ-044 start pulsed again during DATA -> ignored; the counts and addresses of the load in progress are unaffected.

Source files
------------

// File: rtl/inst_loader_pkg.sv
// Shared types and constants for the UART-driven instruction-RAM loader.
package inst_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN,
      ST_DATA,
      ST_WRITE,
      ST_DONE,
      ST_ERROR
   } state_t;

   localparam int unsigned LEN_BYTES  = 4;
   localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/inst_loader_byte_assembler.sv
// Little-endian 8-to-32 packer shared by the length header and the data words.
module byte_assembler
   import inst_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rstn,
   input  logic        clear,
   input  logic        accept,
   input  logic [7:0]  byte_data,
   output logic [31:0] word,
   output logic [1:0]  byte_idx,
   output logic        word_complete
);

   logic [31:0] word_q;

   // word already includes the byte being accepted, so the fourth byte is usable in its own cycle
   always_comb begin
      word = word_q;
      if (accept) begin
         word[{byte_idx, 3'b000} +: 8] = byte_data;
      end
      word_complete = accept && (byte_idx == 2'(WORD_BYTES - 1));
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         word_q   <= '0;
         byte_idx <= '0;
      end else if (clear) begin
         word_q   <= '0;
         byte_idx <= '0;
      end else if (accept) begin
         word_q   <= word;
         byte_idx <= byte_idx + 2'd1;
      end
   end

endmodule

// File: rtl/inst_loader.sv
// Loads a length-prefixed stream of little-endian 32-bit words from a UART into instruction RAM.
module inst_loader
   import inst_loader_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 15,
   parameter int unsigned BASE_ADDR  = 0
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  start,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   output logic                  rx_ready,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic                  ram_enable,
   output logic                  ram_write_enable,
   output logic [31:0]           ram_write_data,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);

   // Compared at 33 bits so that huge lengths never alias onto a legal count
   localparam logic [32:0] MAX_WORDS = (33'd1 << ADDR_WIDTH) - 33'(BASE_ADDR);

   state_t      state;
   logic [31:0] n_words;
   logic [32:0] word_cnt;
   logic        accept;
   logic        asm_clear;
   logic [31:0] asm_word;
   logic [1:0]  asm_idx;
   logic        asm_complete;

   assign accept    = rx_valid && rx_ready;
   assign asm_clear = (state == ST_IDLE) && start;

   byte_assembler u_asm (
      .clk           (clk),
      .rstn          (rstn),
      .clear         (asm_clear),
      .accept        (accept),
      .byte_data     (rx_data),
      .word          (asm_word),
      .byte_idx      (asm_idx),
      .word_complete (asm_complete)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state            <= ST_IDLE;
         n_words          <= '0;
         word_cnt         <= '0;
         rx_ready         <= 1'b0;
         ram_addr         <= '0;
         ram_enable       <= 1'b0;
         ram_write_enable <= 1'b0;
         ram_write_data   <= '0;
         busy             <= 1'b0;
         done             <= 1'b0;
         error            <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state    <= ST_LEN;
                  rx_ready <= 1'b1;
                  busy     <= 1'b1;
                  error    <= 1'b0;
                  word_cnt <= '0;
                  ram_addr <= ADDR_WIDTH'(BASE_ADDR);
               end
            end
            ST_LEN: begin
               if (accept && asm_idx == 2'(LEN_BYTES - 1)) begin
                  n_words <= asm_word;
                  if (asm_word == '0) begin
                     state    <= ST_DONE;
                     rx_ready <= 1'b0;
                     busy     <= 1'b0;
                     done     <= 1'b1;
                  end else if ({1'b0, asm_word} > MAX_WORDS) begin
                     state    <= ST_ERROR;
                     rx_ready <= 1'b0;
                     busy     <= 1'b0;
                     error    <= 1'b1;
                  end else begin
                     state <= ST_DATA;
                  end
               end
            end
            ST_DATA: begin
               if (asm_complete) begin
                  state            <= ST_WRITE;
                  rx_ready         <= 1'b0;
                  ram_enable       <= 1'b1;
                  ram_write_enable <= 1'b1;
                  ram_write_data   <= asm_word;
               end
            end
            ST_WRITE: begin
               ram_enable       <= 1'b0;
               ram_write_enable <= 1'b0;
               ram_addr         <= ram_addr + ADDR_WIDTH'(1);
               word_cnt         <= word_cnt + 33'd1;
               if (word_cnt + 33'd1 == {1'b0, n_words}) begin
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  state    <= ST_DATA;
                  rx_ready <= 1'b1;
               end
            end
            ST_DONE: begin
               done  <= 1'b0;
               state <= ST_IDLE;
            end
            ST_ERROR: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: vector table plus hand-written reset, timing and restart sequences.
module tb_inst_loader;

   localparam int unsigned AW   = 4;
   localparam int unsigned BASE = 0;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          start = 1'b0;
   logic [7:0]    rx_data = '0;
   logic          rx_valid = 1'b0;
   logic          rx_ready;
   logic [AW-1:0] ram_addr;
   logic          ram_enable;
   logic          ram_write_enable;
   logic [31:0]   ram_write_data;
   logic          busy;
   logic          done;
   logic          error;

   inst_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
      .clk              (clk),
      .rstn             (rstn),
      .start            (start),
      .rx_data          (rx_data),
      .rx_valid         (rx_valid),
      .rx_ready         (rx_ready),
      .ram_addr         (ram_addr),
      .ram_enable       (ram_enable),
      .ram_write_enable (ram_write_enable),
      .ram_write_data   (ram_write_data),
      .busy             (busy),
      .done             (done),
      .error            (error)
   );

   always #5 clk = ~clk;

   int            checks = 0;
   int            failures = 0;
   logic [AW-1:0] wr_addr[$];
   logic [31:0]   wr_data[$];
   logic [31:0]   tx_words[$];
   int            done_cnt = 0;
   int            en_bad = 0;

   always @(negedge clk) begin
      if (ram_write_enable) begin
         wr_addr.push_back(ram_addr);
         wr_data.push_back(ram_write_data);
      end
      if (done) done_cnt++;
      if (ram_enable !== ram_write_enable) en_bad++;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int tries;
      if (gap > 0) begin
         rx_valid = 1'b0;
         repeat (gap) @(negedge clk);
      end
      rx_valid = 1'b1;
      rx_data  = b;
      tries    = 0;
      while (!rx_ready && tries < 20) begin
         @(negedge clk);
         tries++;
      end
      if (!rx_ready) begin
         chk("byte_accept_timeout", rx_ready, 1);
         rx_valid = 1'b0;
         return;
      end
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input int gap);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
   endtask

   task automatic pulse_start;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int t = 0;
      while (busy && t < 300) begin
         @(negedge clk);
         t++;
      end
      chk({tag, "_busy_low"}, busy, 0);
      repeat (3) @(negedge clk);
   endtask

   task automatic clear_log;
      wr_addr.delete();
      wr_data.delete();
      done_cnt = 0;
   endtask

   task automatic check_result(input string tag, input bit exp_err);
      chk({tag, "_done_pulses"}, done_cnt, exp_err ? 0 : 1);
      chk({tag, "_error"}, error, exp_err);
      chk({tag, "_write_count"}, wr_addr.size(), exp_err ? 0 : tx_words.size());
      if (!exp_err) begin
         for (int i = 0; i < wr_addr.size() && i < tx_words.size(); i++) begin
            chk($sformatf("%s_addr%0d", tag, i), wr_addr[i], AW'(BASE + i));
            chk($sformatf("%s_data%0d", tag, i), wr_data[i], tx_words[i]);
         end
      end
   endtask

   task automatic run_load(input logic [31:0] n, input int gap, input bit exp_err, input string tag);
      clear_log();
      pulse_start();
      chk({tag, "_busy_after_start"}, busy, 1);
      chk({tag, "_error_cleared"}, error, 0);
      chk({tag, "_rx_ready_len"}, rx_ready, 1);
      send_word(n, gap);
      if (exp_err) begin
         chk({tag, "_error_entry"}, error, 1);
         chk({tag, "_rx_ready_err"}, rx_ready, 0);
         chk({tag, "_busy_err"}, busy, 0);
      end else begin
         foreach (tx_words[i]) send_word(tx_words[i], gap);
      end
      wait_idle(tag);
      check_result(tag, exp_err);
   endtask

   typedef struct {
      logic [31:0] n;
      logic [31:0] w0;
      logic [31:0] w1;
      int          gap;
      bit          exp_err;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int  k;
      bit  prev_err;

      vecs[0] = '{32'd2,          32'hDEADBEEF, 32'h12345678, 0, 1'b0};
      vecs[1] = '{32'd0,          32'h0,        32'h0,        0, 1'b0};
      vecs[2] = '{32'h11,         32'h0,        32'h0,        0, 1'b1};
      vecs[3] = '{32'd1,          32'hA5C30F81, 32'h0,        2, 1'b0};
      vecs[4] = '{32'hFFFFFFFF,   32'h0,        32'h0,        0, 1'b1};
      vecs[5] = '{32'h0001_0001,  32'h0,        32'h0,        0, 1'b1};
      vecs[6] = '{32'd1,          32'h0BADC0DE, 32'h0,        1, 1'b0};

      // reset state
      repeat (3) @(negedge clk);
      chk("reset_outputs",
          {rx_ready, ram_enable, ram_write_enable, busy, done, error, ram_addr, ram_write_data}, '0);
      rstn = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_rx_ready", rx_ready, 0);

      prev_err = 1'b0;
      for (int v = 0; v < 7; v++) begin
         chk($sformatf("v%0d_error_hold", v), error, prev_err);
         tx_words.delete();
         if (!vecs[v].exp_err) begin
            if (vecs[v].n >= 1) tx_words.push_back(vecs[v].w0);
            if (vecs[v].n >= 2) tx_words.push_back(vecs[v].w1);
         end
         run_load(vecs[v].n, vecs[v].gap, vecs[v].exp_err, $sformatf("v%0d", v));
         prev_err = vecs[v].exp_err;
      end

      // zero-length: done visible five cycles after start is raised, for exactly one cycle
      clear_log();
      start    = 1'b1;
      rx_valid = 1'b1;
      rx_data  = 8'h00;
      k = 0;
      while (!done && k < 20) begin
         @(negedge clk);
         k++;
         start = 1'b0;
      end
      rx_valid = 1'b0;
      chk("zero_len_done_latency", k, 5);
      @(negedge clk);
      chk("zero_len_done_width", done, 0);
      repeat (2) @(negedge clk);
      chk("zero_len_no_write", wr_addr.size(), 0);

      // largest legal length fills every address
      tx_words.delete();
      for (int i = 0; i < 16; i++) tx_words.push_back(32'h1000_0000 + 32'(i * 32'h0101));
      run_load(32'd16, 0, 1'b0, "max_len");

      // reset after one full word and two bytes of the next
      clear_log();
      pulse_start();
      send_word(32'd2, 0);
      send_word(32'h01020304, 0);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      rstn = 1'b0;
      #1;
      chk("midload_reset_outputs",
          {rx_ready, ram_enable, ram_write_enable, busy, done, error, ram_addr, ram_write_data}, '0);
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      repeat (3) @(negedge clk);
      chk("midload_write_count", wr_addr.size(), 1);
      chk("midload_done", done_cnt, 0);
      tx_words.delete();
      tx_words.push_back(32'hCAFEF00D);
      run_load(32'd1, 0, 1'b0, "after_reset");

      // start pulse inside DATA must be ignored
      tx_words.delete();
      tx_words.push_back(32'hAAAA5555);
      tx_words.push_back(32'h0F0FF0F0);
      clear_log();
      pulse_start();
      send_word(32'd2, 0);
      send_word(tx_words[0], 0);
      send_byte(tx_words[1][7:0], 0);
      pulse_start();
      for (int i = 1; i < 4; i++) send_byte(tx_words[1][8*i +: 8], 0);
      wait_idle("restart");
      check_result("restart", 1'b0);

      chk("en_we_match", en_bad, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
